dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 147 ++++++++++++++
 tb/tb_dmem_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding request, fixed wait states, byte-lane writes
// into a word-organised RAM, raw 32-bit word returned on reads.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [3:0]              wen_q, wen_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    err_q, err_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    rerr_q, rerr_d;
    logic                    rvalid_q, rvalid_d;

    logic [31:0]             mem [DEPTH];

    logic                    accept;
    logic                    req_err;
    logic                    commit;
    logic [3:0]              c_wen;
    logic [ADDR_WIDTH-1:0]   c_idx;
    logic [31:0]             c_wdata;
    logic                    c_err;

    assign accept  = req_valid && req_ready;
    assign req_err = (req_addr >> (ADDR_WIDTH + 2)) != 32'd0;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            S_WAIT: if (cnt_q == 4'd0) state_d = S_RESP;
            S_RESP: if (resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        req_ready = (state_q == S_IDLE);
    end

    // With zero wait states the commit uses the request inputs directly, otherwise the captured copy.
    always_comb begin
        commit  = 1'b0;
        c_wen   = wen_q;
        c_idx   = idx_q;
        c_wdata = wdata_q;
        c_err   = err_q;
        if (state_q == S_IDLE && accept && WAIT_CYCLES == 0) begin
            commit  = 1'b1;
            c_wen   = req_wen;
            c_idx   = req_addr[ADDR_WIDTH+1:2];
            c_wdata = req_wdata;
            c_err   = req_err;
        end else if (state_q == S_WAIT && cnt_q == 4'd0) begin
            commit  = 1'b1;
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        wen_d    = wen_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        rerr_d   = rerr_q;
        rvalid_d = (state_d == S_RESP);
        if (accept) begin
            cnt_d   = CNT_LOAD;
            wen_d   = req_wen;
            idx_d   = req_addr[ADDR_WIDTH+1:2];
            wdata_d = req_wdata;
            err_d   = req_err;
        end else if (state_q == S_WAIT && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
        if (commit) begin
            rerr_d  = c_err;
            rdata_d = (c_err || c_wen != 4'd0) ? 32'd0 : mem[c_idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= 4'd0;
            wen_q    <= 4'd0;
            idx_q    <= '0;
            wdata_q  <= 32'd0;
            err_q    <= 1'b0;
            rdata_q  <= 32'd0;
            rerr_q   <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            wen_q    <= wen_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
            rvalid_q <= rvalid_d;
        end
    end

    // RAM is never reset; reset only suppresses a commit that would land on the same edge.
    always_ff @(posedge clk) begin
        if (commit && !reset && !c_err) begin
            for (int i = 0; i < 4; i++) begin
                if (c_wen[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
            end
        end
    end

    assign resp_valid = rvalid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = rerr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: latency, lane merge, range error, backpressure, reset.
module tb_dmem_responder;

    localparam int AW = 10;
    localparam int WC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the acceptance edge.
    task automatic issue(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] er, input logic ee);
        int n = 0;
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        sb.push_back('{rdata: er, err: ee});
        #1;
        req_valid = 1'b0;
        req_wen   = 4'd0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        @(negedge clk);
    endtask

    // Waits for the response with resp_ready high, checks latency, data and return to idle.
    task automatic collect(input string tag);
        exp_t e;
        int   n = 1;
        while (!resp_valid && n < 50) begin
            chk({tag, "_busy"}, 32'(req_ready), 32'd0);
            @(negedge clk);
            n++;
        end
        if (!resp_valid) begin
            chk({tag, "_timeout"}, 32'(resp_valid), 32'd1);
            if (sb.size() != 0) void'(sb.pop_front());
            return;
        end
        chk({tag, "_lat"}, 32'(n), 32'(WC + 1));
        chk({tag, "_busy_resp"}, 32'(req_ready), 32'd0);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_rdata"}, resp_rdata, e.rdata);
        chk({tag, "_err"}, 32'(resp_err), 32'(e.err));
        @(negedge clk);
        chk({tag, "_vld_drop"}, 32'(resp_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!resp_valid) chk({tag, "_timeout"}, 32'(resp_valid), 32'd1);
    endtask

    initial begin
        exp_t e;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_wen    = 4'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b1;
        #3;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Lane merge and partial lanes
        issue(4'b1111, 32'h10, 32'hAABBCCDD, 32'd0, 1'b0); collect("wr_full");
        issue(4'b0100, 32'h12, 32'h00EE0000, 32'd0, 1'b0); collect("wr_b2");
        issue(4'b0000, 32'h10, 32'd0, 32'hAAEECCDD, 1'b0); collect("rd_merge");
        issue(4'b0011, 32'h10, 32'h00001234, 32'd0, 1'b0); collect("wr_half");
        issue(4'b0000, 32'h10, 32'd0, 32'hAAEE1234, 1'b0); collect("rd_half");
        issue(4'b1000, 32'h13, 32'h77000000, 32'd0, 1'b0); collect("wr_b3");
        issue(4'b0000, 32'h10, 32'd0, 32'h77EE1234, 1'b0); collect("rd_b3");

        // Out of range: aliases word 0 if the error gate were missing
        issue(4'b1111, 32'h0, 32'h01020304, 32'd0, 1'b0); collect("wr_w0");
        issue(4'b1111, 32'h1000, 32'hDEADBEEF, 32'd0, 1'b1); collect("wr_oor");
        issue(4'b0000, 32'h8000_0000, 32'd0, 32'd0, 1'b1); collect("rd_oor");
        issue(4'b0000, 32'h0, 32'd0, 32'h01020304, 1'b0); collect("rd_w0");
        issue(4'b0000, 32'hFFC, 32'd0, 32'hXXXXXXXX, 1'b0);
        wait_valid("rd_top");
        chk("rd_top_err", 32'(resp_err), 32'd0);
        void'(sb.pop_front());
        @(negedge clk);

        // Backpressure
        resp_ready = 1'b0;
        issue(4'b0000, 32'h10, 32'd0, 32'h77EE1234, 1'b0);
        wait_valid("bp");
        e = (sb.size() != 0) ? sb[0] : '0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_rdata", resp_rdata, e.rdata);
            chk("bp_err", 32'(resp_err), 32'(e.err));
            chk("bp_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        if (sb.size() != 0) void'(sb.pop_front());
        @(negedge clk);
        chk("bp_done_valid", 32'(resp_valid), 32'd0);
        chk("bp_done_ready", 32'(req_ready), 32'd1);

        // Reset mid-WAIT drops the write
        issue(4'b1111, 32'h20, 32'hCAFEF00D, 32'd0, 1'b0); collect("wr_20");
        issue(4'b1111, 32'h20, 32'h11111111, 32'd0, 1'b0);
        reset = 1'b1;
        #1;
        chk("rw_req_ready", 32'(req_ready), 32'd1);
        chk("rw_resp_valid", 32'(resp_valid), 32'd0);
        chk("rw_rdata", resp_rdata, 32'd0);
        chk("rw_err", 32'(resp_err), 32'd0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(4'b0000, 32'h20, 32'd0, 32'hCAFEF00D, 1'b0); collect("rd_20");

        // Reset in RESP: write persists, resp_valid drops asynchronously
        resp_ready = 1'b0;
        issue(4'b0011, 32'h20, 32'h00005A5A, 32'd0, 1'b0);
        wait_valid("rr");
        #2;
        reset = 1'b1;
        #1;
        chk("rr_valid", 32'(resp_valid), 32'd0);
        chk("rr_ready", 32'(req_ready), 32'd1);
        sb.delete();
        resp_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(4'b0000, 32'h20, 32'd0, 32'hCAFE5A5A, 1'b0); collect("rd_rr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
